button_event_gen: RTL

- Consumes the clean, debounced level of a push-button and turns it into single-cycle event pulses: short press, long press and (optionally) auto-repeat.
- Sits directly downstream of the board debouncer, one instance per button.
- Its pulses drive UI logic such as counters and mode selects on the DE0 board.
- Single clock domain; input is already synchronous to clk.

---
 rtl/button_event_gen_pkg.sv | 14 +
 rtl/button_event_gen_if.sv | 18 +
 rtl/button_event_gen_cnt.sv | 23 ++
 rtl/button_event_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared types and 50 MHz default counts for the button event generator.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_e;

  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
  localparam int unsigned DEF_CNT_WIDTH     = 26;

endpackage

// File: rtl/button_event_gen_if.sv
// Button level in, event pulses out; slave side is the event generator.
interface button_event_gen_if;
  logic btn_in;
  logic press_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn_in,
    input  press_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_in,
    output press_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/button_event_gen_cnt.sv
// Loadable up-counter register; load has priority over increment.
module button_event_gen_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      q <= '0;
    end else if (load) begin
      q <= data_in;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Debounced button level -> short/long/auto-repeat single-cycle pulses.
// Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 async_nreset,
  button_event_gen_if.slave    bus
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_event_gen: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  // The counter is cleared on the edge that samples the first 1, so it lags the
  // number of sampled highs by one; comparing with LONG_CYCLES-2 fires on edge E0+LONG_CYCLES-1.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 2);

  btn_state_e           state;
  btn_state_e           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 press_hit;
  logic                 long_hit;
  logic                 rep_hit;
  logic                 cnt_load;
  logic                 cnt_inc;

  always_comb begin
    state_nxt = state;
    press_hit = 1'b0;
    long_hit  = 1'b0;
    rep_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.btn_in) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (!bus.btn_in) begin
          state_nxt = IDLE;
          press_hit = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          long_hit  = 1'b1;
        end
      end
      LONG: begin
        if (!bus.btn_in) begin
          state_nxt = IDLE;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (cnt == CNT_WIDTH'(REPEAT_CYCLES - 1)) begin
          rep_hit = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_load = (state_nxt != state) || rep_hit;
`ifdef BUTTON_AUTOREPEAT_EN
  assign cnt_inc  = (state == PRESSED) || (state == LONG);
`else
  assign cnt_inc  = (state == PRESSED);
`endif

  button_event_gen_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_hold_cnt (
    .clk          (clk),
    .async_nreset (async_nreset),
    .load         (cnt_load),
    .inc          (cnt_inc),
    .data_in      ('0),
    .q            (cnt)
  );

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state           <= IDLE;
      bus.press_pulse <= 1'b0;
      bus.long_pulse  <= 1'b0;
      bus.held        <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.press_pulse <= press_hit;
      bus.long_pulse  <= long_hit;
      bus.held        <= (state_nxt != IDLE);
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) bus.repeat_pulse <= 1'b0;
    else               bus.repeat_pulse <= rep_hit;
  end
`else
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule
